// File: rtl/issue_pkg.sv
// issue_pkg: shared mode/grant types and entry width default for the RF issue arbiter
package issue_pkg;
    localparam int RENISS_WIDTH_DEFAULT = 137;
    typedef enum logic {MODE_LSQ, MODE_IQ} mode_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_IQ, GNT_LSQ} gnt_t;
endpackage

// File: rtl/issue_starve_fsm.sv
// issue_starve_fsm: counts IQ denials and flips priority to IQ once the limit is reached
module issue_starve_fsm
    import issue_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic  CLK,
    input  logic  RESET,
    input  logic  load,
    input  logic  flush,
    input  gnt_t  grant,
    input  logic  IQ_valid,
    output mode_t mode
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt, cnt_nxt;
    mode_t mode_nxt;
    // next counter/mode as they would be after a load edge
    always_comb begin
        cnt_nxt = grant == GNT_IQ ? '0 :
                  (grant == GNT_LSQ && IQ_valid && starve_cnt != LIMIT) ? starve_cnt + 1'b1 : starve_cnt;
        mode_nxt = mode == MODE_LSQ ? (cnt_nxt == LIMIT ? MODE_IQ : MODE_LSQ) :
                   (grant == GNT_IQ ? MODE_LSQ : MODE_IQ);
    end
    // state register: flush restarts in LSQ mode, otherwise advance only on load
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mode <= MODE_LSQ;
            starve_cnt <= '0;
        end else if (flush) begin
            mode <= MODE_LSQ;
            starve_cnt <= '0;
        end else if (load) begin
            mode <= mode_nxt;
            starve_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/rf_issue_arbiter.sv
// rf_issue_arbiter: picks one ready IQ/LSQ head per cycle and registers it for the RF stage
module rf_issue_arbiter
    import issue_pkg::*;
#(
    parameter int RENISS_WIDTH = RENISS_WIDTH_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FREEZE,
    input  logic                    FLUSH,
    input  logic                    IQ_valid,
    input  logic [RENISS_WIDTH-1:0] IQ_data,
    input  logic                    LSQ_valid,
    input  logic [RENISS_WIDTH-1:0] LSQ_data,
    output logic                    IQ_pop,
    output logic                    LSQ_pop,
    output logic [RENISS_WIDTH-1:0] IQLSQ_popData_OUT,
    output logic                    Valid_Instruction_OUT,
    output logic                    Mem_Instruction_OUT
);
    logic load;
    gnt_t grant;
    mode_t mode;
    assign load = RESET & ~FREEZE & ~FLUSH;
    // grant the queue the mode prefers, falling back to the other one
    always_comb begin
        grant = mode == MODE_LSQ ?
                (LSQ_valid ? GNT_LSQ : IQ_valid ? GNT_IQ : GNT_NONE) :
                (IQ_valid ? GNT_IQ : LSQ_valid ? GNT_LSQ : GNT_NONE);
    end
    assign IQ_pop  = load & (grant == GNT_IQ);
    assign LSQ_pop = load & (grant == GNT_LSQ);
    issue_starve_fsm #(.STARVE_LIMIT(STARVE_LIMIT)) u_fsm (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (load),
        .flush    (FLUSH),
        .grant    (grant),
        .IQ_valid (IQ_valid),
        .mode     (mode)
    );
    // RF input register: capture the winner, bubble on no grant or flush, data holds on bubbles
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            IQLSQ_popData_OUT <= '0;
            Valid_Instruction_OUT <= 1'b0;
            Mem_Instruction_OUT <= 1'b0;
        end else if (FLUSH) begin
            Valid_Instruction_OUT <= 1'b0;
            Mem_Instruction_OUT <= 1'b0;
        end else if (load) begin
            if (grant != GNT_NONE)
                IQLSQ_popData_OUT <= grant == GNT_LSQ ? LSQ_data : IQ_data;
            Valid_Instruction_OUT <= grant != GNT_NONE;
            Mem_Instruction_OUT <= grant == GNT_LSQ;
        end
    end
endmodule

// File: doc/rf_issue_arbiter.md
# rf_issue_arbiter

Issue arbiter between the Issue Queue (IQ) and the Load/Store Queue (LSQ) that feeds the register-read (RF) stage. Each cycle it selects at most one ready entry, pulses the winning queue's pop, and registers the entry with valid and memory-type qualifiers as the RF stage's input. LSQ has default priority. A starvation counter with a two-state mode FSM guarantees IQ forward progress. The arbiter honours the pipeline FREEZE and a mispredict FLUSH.

## Interface
- RENISS_WIDTH, 137, width of a queue entry (bits 136:0 used by RF)
- STARVE_LIMIT, 4, consecutive IQ denials before IQ gets priority (≥1)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- FREEZE  in  1  downstream stall; hold all state
- FLUSH  in  1  squash in-flight selection; priority over FREEZE
- IQ_valid  in  1  IQ head ready to issue
- IQ_data  in  RENISS_WIDTH  IQ head entry
- LSQ_valid  in  1  LSQ head ready to issue
- LSQ_data  in  RENISS_WIDTH  LSQ head entry
- IQ_pop  out  1  IQ head consumed this cycle (combinational)
- LSQ_pop  out  1  LSQ head consumed this cycle (combinational)
- IQLSQ_popData_OUT  out  RENISS_WIDTH  registered selected entry
- Valid_Instruction_OUT  out  1  registered; entry valid
- Mem_Instruction_OUT  out  1  registered; entry came from LSQ

## Operation
- load = RESET & !FREEZE & !FLUSH.
- Mode FSM states: MODE_LSQ (reset state) and MODE_IQ.
- Grant in MODE_LSQ: LSQ if LSQ_valid, else IQ if IQ_valid, else none.
- Grant in MODE_IQ: IQ if IQ_valid, else LSQ if LSQ_valid, else none.
- IQ_pop = load & grant==IQ; LSQ_pop = load & grant==LSQ. At most one pop is high. Both pops are 0 while RESET is low.
- On a load edge with a grant: the data register takes the winner's data, Valid_Instruction_OUT←1, and Mem_Instruction_OUT←(grant==LSQ).
- On a load edge with no grant: Valid_Instruction_OUT←0 and Mem_Instruction_OUT←0 (bubble). The data register holds.
- starve_cnt is $clog2(STARVE_LIMIT+1) bits wide and updates only on load edges:
  - grant==IQ → 0.
  - grant==LSQ & IQ_valid → +1, saturating at STARVE_LIMIT.
  - otherwise hold.
- Mode transitions, load edges only:
  - MODE_LSQ→MODE_IQ when the next starve_cnt == STARVE_LIMIT.
  - MODE_IQ→MODE_LSQ on grant==IQ.
  - If IQ_valid drops while in MODE_IQ, the FSM stays in MODE_IQ and the counter holds saturated until IQ is granted.
- FREEZE (without FLUSH): no pops; data register, valid, mem, mode and counter all hold.
- FLUSH: no pops. At the next edge Valid_Instruction_OUT←0, Mem_Instruction_OUT←0, mode←MODE_LSQ, starve_cnt←0. The data register holds. This applies regardless of FREEZE.
- Reset (async, any time): every output register is 0, including IQLSQ_popData_OUT; mode is MODE_LSQ and starve_cnt is 0. An entry in flight is dropped; the queues own recovery.

## Timing
- The grant/pop path is combinational from IQ_valid, LSQ_valid, FREEZE, FLUSH and mode. The queue dequeues on the same rising edge that captures the data.
- Latency: an entry popped in cycle N appears on the outputs in cycle N+1. RF registers it again, so operands are valid at N+2.
- Throughput: one entry per unfrozen cycle.
- Back-to-back grants from the same queue are allowed; the queue presents its new head in the following cycle.
- FLUSH and FREEZE are sampled together; FLUSH wins.

## Structure
- Shared package `issue_pkg`:
  - mode enum {MODE_LSQ, MODE_IQ}
  - grant encoding {GNT_NONE, GNT_IQ, GNT_LSQ}
  - the RENISS_WIDTH default
- One natural sub-module, `issue_starve_fsm`. It holds the mode FSM and starve_cnt; its inputs are load, the grant and IQ_valid, and its output is the mode.
- The top level holds the grant mux, the pop logic and the output register.

## Test plan
- Reset: assert RESET low mid-stream with both queues valid → all outputs 0 and no pop; after release the first grant goes to LSQ.
- Only IQ_valid, IQ_data=0x…A5 → IQ_pop high in that cycle; next cycle IQLSQ_popData_OUT=0x…A5, Valid=1, Mem=0.
- Both queues valid for 12 cycles, STARVE_LIMIT=4 → grant sequence L,L,L,L,I,L,L,L,L,I,L,L; Mem_Instruction_OUT follows one cycle later.
- Both valid, FREEZE high for 3 cycles after two LSQ grants → no pops and outputs stable for 3 cycles; after release, two more LSQ grants then IQ.
- FLUSH together with FREEZE while in MODE_IQ → no pop; next cycle Valid=0 and Mem=0; the following grant with both queues valid goes to LSQ.
- Neither queue valid for 2 cycles → Valid=0, Mem=0, data register unchanged, starve_cnt unchanged.
